// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter.
package sprite_pkg;

  localparam int PIX_W   = 17;  // ROM pixel index and framebuffer address
  localparam int COLOR_W = 16;  // RGB565
  localparam int DIM_W   = 9;   // sprite dimensions and screen coordinates

  localparam int                 FB_WIDTH_DEFAULT  = 320;
  localparam int                 FB_HEIGHT_DEFAULT = 240;
  localparam logic [COLOR_W-1:0] KEY_COLOR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Framebuffer write port between the blitter and the write arbiter.
//
// Handshake: the master raises fb_valid with fb_addr/fb_data and holds all
// three stable until a cycle where fb_ready is also high; the write happens
// on that rising edge. fb_ready while fb_valid is low means nothing.
interface sprite_blitter_if;
  import sprite_pkg::*;

  logic [PIX_W-1:0]   fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_valid;
  logic               fb_ready;

  modport master (output fb_addr, output fb_data, output fb_valid, input fb_ready);
  modport slave  (input fb_addr, input fb_data, input fb_valid, output fb_ready);

endinterface

// File: rtl/sprite_scan_counter.sv
// Row-major column/row/pixel-index counters for scanning a sprite.
module sprite_scan_counter
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic [PIX_W-1:0] pixel,
  output logic             last
);

  logic end_of_row;

  // Current position is the final pixel of a row / of the sprite.
  always_comb begin
    end_of_row = (col == width - 9'd1);
    last       = end_of_row && (row == height - 9'd1);
  end

  // Counters: clear on a new blit, step one pixel per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      pixel <= '0;
    end else if (clear) begin
      col   <= '0;
      row   <= '0;
      pixel <= '0;
    end else if (advance) begin
      pixel <= pixel + 17'd1;
      if (end_of_row) begin
        col <= '0;
        row <= row + 9'd1;
      end else begin
        col <= col + 9'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a ROM sprite into the framebuffer, skipping key-colour and
// off-screen pixels; one framebuffer write per visible opaque pixel.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int                 FB_WIDTH  = FB_WIDTH_DEFAULT,
  parameter int                 FB_HEIGHT = FB_HEIGHT_DEFAULT,
  parameter logic [COLOR_W-1:0] KEY_COLOR = KEY_COLOR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIM_W-1:0]   x0,
  input  logic [DIM_W-1:0]   y0,
  output logic               busy,
  output logic               done,
  output logic [PIX_W-1:0]   pixel,
  input  logic [COLOR_W-1:0] color,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  sprite_blitter_if.master   fb,
  output blit_state_t        dbg_state
);

  blit_state_t        state, state_next;
  logic [DIM_W-1:0]   x0_q, y0_q, width_q, height_q;
  logic [DIM_W-1:0]   col, row;
  logic               last, clear, advance, load_fb;
  logic [9:0]         scr_x, scr_y;
  logic               skip;
  logic [PIX_W-1:0]   lin_addr;
  logic [PIX_W-1:0]   fb_addr_q;
  logic [COLOR_W-1:0] fb_data_q;

  sprite_scan_counter u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .advance (advance),
    .width   (width_q),
    .height  (height_q),
    .col     (col),
    .row     (row),
    .pixel   (pixel),
    .last    (last)
  );

  // Screen position of the current pixel; 10-bit sums so nothing wraps back on-screen.
  always_comb begin
    scr_x    = {1'b0, x0_q} + {1'b0, col};
    scr_y    = {1'b0, y0_q} + {1'b0, row};
    skip     = (color == KEY_COLOR) || (scr_x >= 10'(FB_WIDTH)) || (scr_y >= 10'(FB_HEIGHT));
    lin_addr = 17'(scr_y) * 17'(FB_WIDTH) + 17'(scr_x);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and counter control.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    advance    = 1'b0;
    load_fb    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = (width == '0 || height == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (skip) begin
          advance    = 1'b1;
          state_next = last ? ST_DONE : ST_FETCH;
        end else begin
          load_fb    = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (fb.fb_ready) begin
          advance    = 1'b1;
          state_next = last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Blit parameters latched at accept so ROM/input changes mid-blit are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q     <= '0;
      y0_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else if (state == ST_IDLE && start) begin
      x0_q     <= x0;
      y0_q     <= y0;
      width_q  <= width;
      height_q <= height;
    end
  end

  // Write address/data captured in FETCH and held through WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else if (load_fb) begin
      fb_addr_q <= lin_addr;
      fb_data_q <= color;
    end
  end

  assign fb.fb_addr  = fb_addr_q;
  assign fb.fb_data  = fb_data_q;
  assign fb.fb_valid = (state == ST_WRITE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a write scoreboard.
module tb_sprite_blitter;
  import sprite_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  x0, y0, width, height;
  logic        busy, done;
  logic [16:0] pixel;
  logic [15:0] color;
  blit_state_t dbg_state;
  logic [15:0] rom [0:63];

  sprite_blitter_if fb ();

  sprite_blitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .busy      (busy),
    .done      (done),
    .pixel     (pixel),
    .color     (color),
    .width     (width),
    .height    (height),
    .fb        (fb.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: combinational read
  always_comb begin
    color = 16'h0000;
    if (pixel < 17'd64) color = rom[pixel[5:0]];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  logic [32:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_write(input int addr, input logic [15:0] data);
    exp_q.push_back({17'(addr), data});
  endtask

  // Write monitor: every completed handshake must match the next expected write
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && fb.fb_valid && fb.fb_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(fb.fb_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(fb.fb_addr), 32'(e[32:16]));
        check("wr_data", 32'(fb.fb_data), 32'(e[15:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_blit(input int x, input int y, input int w, input int h);
    @(negedge clk);
    x0 = 9'(x); y0 = 9'(y); width = 9'(w); height = 9'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
  endtask

  // Returns the cycle number of done, counting the cycle start was high as 1
  task automatic wait_done(input int max_edges, input bit poke, output int cyc);
    @(negedge clk);
    while (!done && edges < max_edges) begin
      @(posedge clk);
      edges++;
      #1;
      if (poke && edges == 3) begin
        start = 1'b1; x0 = 9'd100; width = 9'd1;
      end else if (poke) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(done), 32'd1);
    cyc = edges + 1;
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!fb.fb_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", 32'(fb.fb_valid), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_valid"}, 32'(fb.fb_valid), 32'd0);
    check({tag, "_pixel"}, 32'(pixel), 32'd0);
    check({tag, "_addr"},  32'(fb.fb_addr), 32'd0);
    check({tag, "_data"},  32'(fb.fb_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0;
    fb.fb_ready = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 16'(i + 256);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2 opaque at (10,20)
    rom[0] = 16'd1; rom[1] = 16'd2; rom[2] = 16'd3; rom[3] = 16'd4;
    expect_write(6410, 16'd1); expect_write(6411, 16'd2);
    expect_write(6730, 16'd3); expect_write(6731, 16'd4);
    start_blit(10, 20, 2, 2);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_state_fetch", 32'(dbg_state), 32'(ST_FETCH));
    wait_done(100, 1'b0, cyc);
    check("t1_done_cycle", 32'(cyc), 32'd10);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 3x1 with transparent middle pixel
    rom[0] = 16'h0005; rom[1] = 16'hFFFF; rom[2] = 16'h0007;
    expect_write(0, 16'h0005); expect_write(2, 16'h0007);
    start_blit(0, 0, 3, 1);
    wait_done(100, 1'b0, cyc);
    check("t2_done_cycle", 32'(cyc), 32'd7);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 4x4 at the bottom-right corner: only 2x2 visible
    for (int i = 0; i < 16; i++) rom[i] = 16'(i + 256);
    expect_write(76478, 16'h0100); expect_write(76479, 16'h0101);
    expect_write(76798, 16'h0104); expect_write(76799, 16'h0105);
    start_blit(318, 238, 4, 4);
    wait_done(200, 1'b0, cyc);
    check("t3_done_cycle", 32'(cyc), 32'd22);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: fb_ready low for 5 cycles on the first write
    rom[0] = 16'h1234; rom[1] = 16'h5678;
    fb.fb_ready = 1'b0;
    expect_write(1605, 16'h1234); expect_write(1606, 16'h5678);
    start_blit(5, 5, 2, 1);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(fb.fb_valid), 32'd1);
      check("t4_hold_addr", 32'(fb.fb_addr), 32'd1605);
      check("t4_hold_data", 32'(fb.fb_data), 32'h1234);
      check("t4_hold_pixel", 32'(pixel), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    fb.fb_ready = 1'b1;
    wait_done(100, 1'b0, cyc);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // start while busy (with new x0/width) is ignored
    rom[0] = 16'd1; rom[1] = 16'd2; rom[2] = 16'd3; rom[3] = 16'd4;
    expect_write(0, 16'd1); expect_write(1, 16'd2);
    expect_write(320, 16'd3); expect_write(321, 16'd4);
    start_blit(0, 0, 2, 2);
    wait_done(100, 1'b1, cyc);
    start = 1'b0;
    check("t5_done_cycle", 32'(cyc), 32'd10);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero-width blit: done 2 cycles after start, no writes
    start_blit(0, 0, 0, 3);
    wait_done(20, 1'b0, cyc);
    check("t6_done_cycle", 32'(cyc), 32'd2);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset during WRITE
    rom[0] = 16'h00AA;
    fb.fb_ready = 1'b0;
    start_blit(1, 1, 1, 1);
    wait_valid(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_valid_drop", 32'(fb.fb_valid), 32'd0);
    check("t7_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("t7_post");
    fb.fb_ready = 1'b1;
    @(negedge clk);
    check("t7_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Copies one bitmap sprite out of an image ROM into the framebuffer at a chosen screen position. On `start` it scans the ROM row-major and skips transparent (key-colour) pixels and pixels that fall off-screen. Every remaining pixel goes to the framebuffer write port through a valid/ready handshake. It sits between the bitmap ROM modules and the framebuffer write arbiter, and is the consumer of their `pixel`/`color`/`width`/`height` interface.

## Interface
- `FB_WIDTH`, 320, framebuffer width in pixels
- `FB_HEIGHT`, 240, framebuffer height in pixels
- `KEY_COLOR`, 16'hFFFF, RGB565 transparent colour; never written
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a blit; sampled only in IDLE
- `x0`  in  9  screen column of sprite's top-left pixel
- `y0`  in  9  screen row of sprite's top-left pixel
- `busy`  out  1  high from cycle after accepted `start` until DONE completes
- `done`  out  1  one-cycle pulse at end of blit
- `pixel`  out  17  ROM index, row*width+col
- `color`  in  16  ROM data for `pixel`, combinational, same cycle
- `width`  in  9  sprite width from ROM (1-based count)
- `height`  in  9  sprite height from ROM (1-based count)
- `fb_addr`  out  17  framebuffer address, y*FB_WIDTH+x
- `fb_data`  out  16  RGB565 pixel to write
- `fb_valid`  out  1  write request
- `fb_ready`  in  1  framebuffer accepts write when high with `fb_valid`

## Operation
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - On `start`, latch `x0`, `y0`, `width`, `height`, and clear col/row/pixel counters.
  - If `width`==0 or `height`==0, go to DONE; otherwise go to FETCH.
- FETCH:
  - Drive `pixel` = counter and sample `color`.
  - Form screen x = x0+col and y = y0+row as 10-bit unsigned sums (no wrap).
  - Skip the pixel if `color`==KEY_COLOR, x≥FB_WIDTH, or y≥FB_HEIGHT. A skip advances and stays in FETCH, or goes to DONE if the pixel was the last one.
  - Otherwise register `fb_addr`, `fb_data`=`color`, assert `fb_valid`, and go to WRITE.
- WRITE:
  - Hold `fb_addr`, `fb_data` and `fb_valid` stable until `fb_ready`.
  - On the handshake, deassert `fb_valid`, then advance.
- Advance:
  - `pixel`+1 and col+1.
  - If col==width−1: col=0, row+1.
  - If the advanced pixel was last (col==width−1 and row==height−1): go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored while not in IDLE.
- ROM inputs are latched at accept; `width`/`height` changes mid-blit have no effect.
- Address arithmetic is 17-bit; the maximum 239*320+319=76799 fits.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `fb_valid`=0, `pixel`=0, `fb_addr`=0, `fb_data`=0.
- `start` sampled at edge N: `busy`=1 and first FETCH in cycle N+1.
- Skipped pixel: 1 cycle.
- Written pixel: 1 FETCH cycle plus WRITE cycles until `fb_ready` (minimum 2).
- Full opaque 29×32 sprite with `fb_ready` tied high: 1856 busy cycles in FETCH/WRITE, then `done` in cycle 1858 after `start`. `busy` stays high during the DONE cycle and drops the next cycle.
- `fb_ready` asserted while `fb_valid`=0 has no effect.
- Reset asserted mid-blit: immediate (async) return to reset values; no partial handshake completes.
- `start` in the DONE cycle is ignored; it is accepted from the following IDLE cycle.

## Structure
- Package `sprite_pkg` holds:
  - state enum `blit_state_t`;
  - `FB_WIDTH`/`FB_HEIGHT` defaults and `KEY_COLOR` default (16'hFFFF);
  - width constants: pixel index 17, colour 16, dimension 9.
- One sub-module: `sprite_scan_counter`, holding the col/row/pixel counters with `advance`, `clear` and `last` outputs.
- The FSM and framebuffer address calculation stay in `sprite_blitter`.

## Test plan
- 2×2 all-opaque sprite (colours 1, 2, 3, 4) at (10, 20), `fb_ready`=1:
  - writes go to addrs 6410, 6411, 6730, 6731 with data 1, 2, 3, 4 in order;
  - `done` arrives 10 cycles after `start`.
- 3×1 sprite with middle pixel 16'hFFFF: exactly 2 writes, at col 0 and col 2; the skip takes 1 cycle.
- Sprite at (318, 238), size 4×4: only 4 writes (x∈{318, 319}, y∈{238, 239}); the others are skipped; `done` is still pulsed.
- `fb_ready` held low 5 cycles on the first write: `fb_valid`, `fb_addr` and `fb_data` stay stable all 5 cycles, and the pixel counter does not advance.
- `start` pulsed while busy, and `width`=0 start: mid-blit `start` ignored; the zero-size blit gives `done` 2 cycles after `start` with no writes.
- `rst_n` low during WRITE: `fb_valid` drops immediately; after release the block is in IDLE with all outputs 0.
